tick_monitor: RTL and testbench

Receive-side checker for the periodic carry/terminal-count strobe produced by the team's modulo-N enabled counters. It counts enabled cycles between strobes and declares lock after a run of correct periods. Once locked, it flywheels across missing strobes, flags and realigns on early strobes, and drops lock after repeated misses. It sits downstream of a divider or counter chain and provides a cleaned strobe, a lock flag and error statistics to the DNCCTP subsystem control logic.

---
 rtl/tick_monitor.sv | 179 +++++++++++++++++
 tb/tb_tick_monitor.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/tick_monitor.sv
// tick_monitor: checks the periodic terminal-count strobe of a modulo-N enabled counter.
// It acquires and holds lock, flywheels across missing strobes and keeps error statistics.
module tick_monitor #(
    parameter int N          = 64,
    parameter int LOCK_COUNT = 4,
    parameter int MISS_LIMIT = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   tick,
    output logic                   ftick,
    output logic                   locked,
    output logic                   err,
    output logic [$clog2(N):0]     period,
    output logic [7:0]             err_cnt
);

    localparam int IW = $clog2(N);
    localparam int PW = IW + 1;
    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int MW = $clog2(MISS_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [IW-1:0]   ivl_r;
    logic [IW-1:0]   ivl_nxt_s;
    logic [GW-1:0]   gcnt_r;
    logic [GW-1:0]   gcnt_nxt_s;
    logic [MW-1:0]   mcnt_r;
    logic [MW-1:0]   mcnt_nxt_s;
    logic            locked_r;
    logic            err_r;
    logic            err_evt_s;
    logic [PW-1:0]   period_r;
    logic [7:0]      err_cnt_r;

    logic valid_s;
    logic at_end_s;
    logic good_s;
    logic early_s;
    logic miss_s;
    logic proto_s;
    logic gcnt_hit_s;
    logic mcnt_hit_s;

    assign valid_s    = en & tick;
    assign at_end_s   = (ivl_r == IW'(N - 1));
    assign good_s     = valid_s & at_end_s;
    assign early_s    = valid_s & ~at_end_s;
    assign miss_s     = en & ~tick & at_end_s;
    assign proto_s    = tick & ~en;
    assign gcnt_hit_s = (gcnt_r == GW'(LOCK_COUNT - 1));
    assign mcnt_hit_s = (mcnt_r == MW'(MISS_LIMIT - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (valid_s) state_nxt_s = ACQ;
                else         state_nxt_s = IDLE;
            end
            ACQ: begin
                if (good_s && gcnt_hit_s) state_nxt_s = LOCK;
                else if (miss_s)          state_nxt_s = IDLE;
                else                      state_nxt_s = ACQ;
            end
            LOCK: begin
                if ((early_s || miss_s) && mcnt_hit_s) state_nxt_s = IDLE;
                else                                   state_nxt_s = LOCK;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs: error event, flywheel strobe and counter updates
    always_comb begin
        err_evt_s  = proto_s;
        ftick      = en & (state_r == LOCK) & at_end_s;
        gcnt_nxt_s = gcnt_r;
        mcnt_nxt_s = mcnt_r;
        ivl_nxt_s  = ivl_r;
        if (state_r == IDLE) begin
            ivl_nxt_s = IW'(0);
        end else if (valid_s || miss_s) begin
            ivl_nxt_s = IW'(0);
        end else if (en) begin
            ivl_nxt_s = ivl_r + IW'(1);
        end else begin
            ivl_nxt_s = ivl_r;
        end
        case (state_r)
            IDLE: begin
                if (valid_s) gcnt_nxt_s = GW'(0);
                else         gcnt_nxt_s = gcnt_r;
            end
            ACQ: begin
                if (good_s && gcnt_hit_s) begin
                    gcnt_nxt_s = GW'(0);
                    mcnt_nxt_s = MW'(0);
                end else if (good_s) begin
                    gcnt_nxt_s = gcnt_r + GW'(1);
                end else if (early_s || miss_s) begin
                    gcnt_nxt_s = GW'(0);
                    err_evt_s  = 1'b1;
                end else begin
                    gcnt_nxt_s = gcnt_r;
                end
            end
            LOCK: begin
                if (good_s) begin
                    mcnt_nxt_s = MW'(0);
                end else if (early_s || miss_s) begin
                    err_evt_s = 1'b1;
                    if (mcnt_hit_s) mcnt_nxt_s = MW'(0);
                    else            mcnt_nxt_s = mcnt_r + MW'(1);
                end else begin
                    mcnt_nxt_s = mcnt_r;
                end
            end
            default: begin
                gcnt_nxt_s = GW'(0);
                mcnt_nxt_s = MW'(0);
            end
        endcase
    end

    // Interval, good-period and miss counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ivl_r  <= IW'(0);
            gcnt_r <= GW'(0);
            mcnt_r <= MW'(0);
        end else begin
            ivl_r  <= ivl_nxt_s;
            gcnt_r <= gcnt_nxt_s;
            mcnt_r <= mcnt_nxt_s;
        end
    end

    // Registered status: lock flag, error pulse, measured period, saturating error count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked_r  <= 1'b0;
            err_r     <= 1'b0;
            period_r  <= PW'(0);
            err_cnt_r <= 8'd0;
        end else begin
            locked_r <= (state_nxt_s == LOCK);
            err_r    <= err_evt_s;
            if (valid_s) period_r <= PW'(ivl_r) + PW'(1);
            else         period_r <= period_r;
            if (err_evt_s && (err_cnt_r != 8'hFF)) err_cnt_r <= err_cnt_r + 8'd1;
            else                                   err_cnt_r <= err_cnt_r;
        end
    end

    assign locked  = locked_r;
    assign err     = err_r;
    assign period  = period_r;
    assign err_cnt = err_cnt_r;

endmodule

// File: tb/tb_tick_monitor.sv
// Directed bench for tick_monitor with N=8, LOCK_COUNT=4, MISS_LIMIT=2.
// A table of strobe slots drives the main scenarios; hand sequences cover gating, reset and saturation.
module tb_tick_monitor;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       tick;
    logic       ftick;
    logic       locked;
    logic       err;
    logic [3:0] period;
    logic [7:0] err_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    tick_monitor #(.N(8), .LOCK_COUNT(4), .MISS_LIMIT(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .tick    (tick),
        .ftick   (ftick),
        .locked  (locked),
        .err     (err),
        .period  (period),
        .err_cnt (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int gap;
        bit tk;
        bit e_ftick;
        bit e_locked;
        bit e_err;
        int e_period;
        int e_errcnt;
    } vec_t;

    vec_t vecs [19];

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act != exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else            pass_cnt++;
    endtask

    // One clock: drive inputs, sample ftick mid-cycle, return just after the edge.
    task automatic cyc(input bit e, input bit t, output bit ft);
        en   = e;
        tick = t;
        @(negedge clk);
        ft = ftick;
        @(posedge clk);
        #1;
    endtask

    // gap enabled cycles, strobe (or its absence) on the last one; optional en=0 cycle before each.
    task automatic run_gap(input int gap, input bit tk, input bit gated, output bit ft_slot);
        bit ft;
        for (int k = 1; k <= gap; k++) begin
            if (gated) begin
                cyc(1'b0, 1'b0, ft);
                chk("ftick_gated_off", int'(ft), 0);
            end
            if (k < gap) begin
                cyc(1'b1, 1'b0, ft);
                chk("ftick_between", int'(ft), 0);
            end else begin
                cyc(1'b1, tk, ft);
                ft_slot = ft;
            end
        end
    endtask

    task automatic reset_dut();
        en    = 1'b0;
        tick  = 1'b0;
        rst_n = 1'b0;
        #12;
        chk("rst_locked", int'(locked), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_period", int'(period), 0);
        chk("rst_errcnt", int'(err_cnt), 0);
        chk("rst_ftick", int'(ftick), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit ft;
        vecs[0]  = '{1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0};
        vecs[1]  = '{8, 1'b1, 1'b0, 1'b0, 1'b0, 8, 0};
        vecs[2]  = '{8, 1'b1, 1'b0, 1'b0, 1'b0, 8, 0};
        vecs[3]  = '{8, 1'b1, 1'b0, 1'b0, 1'b0, 8, 0};
        vecs[4]  = '{8, 1'b1, 1'b0, 1'b1, 1'b0, 8, 0};
        vecs[5]  = '{8, 1'b1, 1'b1, 1'b1, 1'b0, 8, 0};
        vecs[6]  = '{8, 1'b0, 1'b1, 1'b1, 1'b1, 8, 1};
        vecs[7]  = '{8, 1'b1, 1'b1, 1'b1, 1'b0, 8, 1};
        vecs[8]  = '{8, 1'b0, 1'b1, 1'b1, 1'b1, 8, 2};
        vecs[9]  = '{8, 1'b1, 1'b1, 1'b1, 1'b0, 8, 2};
        vecs[10] = '{5, 1'b1, 1'b0, 1'b1, 1'b1, 5, 3};
        vecs[11] = '{8, 1'b1, 1'b1, 1'b1, 1'b0, 8, 3};
        vecs[12] = '{8, 1'b0, 1'b1, 1'b1, 1'b1, 8, 4};
        vecs[13] = '{8, 1'b0, 1'b1, 1'b0, 1'b1, 8, 5};
        vecs[14] = '{8, 1'b0, 1'b0, 1'b0, 1'b0, 8, 5};
        vecs[15] = '{1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 5};
        vecs[16] = '{3, 1'b1, 1'b0, 1'b0, 1'b1, 3, 6};
        vecs[17] = '{8, 1'b0, 1'b0, 1'b0, 1'b1, 3, 7};
        vecs[18] = '{1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 7};

        reset_dut();

        for (int i = 0; i < 19; i++) begin
            run_gap(vecs[i].gap, vecs[i].tk, 1'b0, ft);
            chk($sformatf("v%0d_ftick", i), int'(ft), int'(vecs[i].e_ftick));
            chk($sformatf("v%0d_locked", i), int'(locked), int'(vecs[i].e_locked));
            chk($sformatf("v%0d_err", i), int'(err), int'(vecs[i].e_err));
            chk($sformatf("v%0d_period", i), int'(period), vecs[i].e_period);
            chk($sformatf("v%0d_errcnt", i), int'(err_cnt), vecs[i].e_errcnt);
        end

        // Gated enable: lock over alternating en, counting enabled cycles only.
        reset_dut();
        run_gap(1, 1'b1, 1'b1, ft);
        for (int i = 0; i < 4; i++) begin
            run_gap(8, 1'b1, 1'b1, ft);
            chk("gate_acq_ftick", int'(ft), 0);
        end
        chk("gate_locked", int'(locked), 1);
        chk("gate_period", int'(period), 8);
        chk("gate_errcnt0", int'(err_cnt), 0);
        run_gap(8, 1'b1, 1'b1, ft);
        chk("gate_lock_ftick", int'(ft), 1);

        // Protocol error: tick while en=0 only bumps the error statistics.
        cyc(1'b0, 1'b1, ft);
        chk("proto_err", int'(err), 1);
        chk("proto_errcnt", int'(err_cnt), 1);
        chk("proto_locked", int'(locked), 1);
        chk("proto_period", int'(period), 8);
        cyc(1'b0, 1'b0, ft);
        chk("proto_err_drop", int'(err), 0);
        run_gap(8, 1'b1, 1'b1, ft);
        chk("proto_phase_ftick", int'(ft), 1);
        chk("proto_phase_err", int'(err), 0);
        chk("proto_phase_locked", int'(locked), 1);

        // Asynchronous reset while locked, away from any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_locked", int'(locked), 0);
        chk("arst_errcnt", int'(err_cnt), 0);
        chk("arst_period", int'(period), 0);
        chk("arst_err", int'(err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_gap(8, 1'b1, 1'b0, ft);
        chk("arst_no_ftick", int'(ft), 0);
        chk("arst_relock_locked", int'(locked), 0);
        chk("arst_relock_err", int'(err), 0);

        // Error counter saturation.
        for (int i = 0; i < 300; i++) cyc(1'b0, 1'b1, ft);
        chk("sat_errcnt", int'(err_cnt), 255);
        chk("sat_err", int'(err), 1);
        chk("sat_locked", int'(locked), 0);
        cyc(1'b0, 1'b0, ft);
        chk("sat_hold", int'(err_cnt), 255);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
